// File: rtl/lt24_pixel_writer_pkg.sv
// Shared LT24 command codes, bus-phase states and the address-sequence word table.
package lt24_pixel_writer_pkg;

    localparam logic [7:0] LT24_CMD_COLADDR  = 8'h2A;
    localparam logic [7:0] LT24_CMD_PAGEADDR = 8'h2B;
    localparam logic [7:0] LT24_CMD_MEMWRITE = 8'h2C;

    localparam logic [3:0] LAST_IDX = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } bus_state_e;

    // Returns {rs, data} for word idx of the full sequence; idx 11 is the colour.
    function automatic logic [16:0] seq_word(
        input logic [3:0]  idx,
        input logic [7:0]  x,
        input logic [8:0]  y,
        input logic [15:0] colour,
        input logic [15:0] x_end,
        input logic [15:0] y_end
    );
        logic [16:0] w;
        w = {1'b1, 16'h0000};
        case (idx)
            4'd0:    w = {1'b0, 8'h00, LT24_CMD_COLADDR};
            4'd1:    w = {1'b1, 16'h0000};
            4'd2:    w = {1'b1, 8'h00, x};
            4'd3:    w = {1'b1, 8'h00, x_end[15:8]};
            4'd4:    w = {1'b1, 8'h00, x_end[7:0]};
            4'd5:    w = {1'b0, 8'h00, LT24_CMD_PAGEADDR};
            4'd6:    w = {1'b1, 15'h0000, y[8]};
            4'd7:    w = {1'b1, 8'h00, y[7:0]};
            4'd8:    w = {1'b1, 8'h00, y_end[15:8]};
            4'd9:    w = {1'b1, 8'h00, y_end[7:0]};
            4'd10:   w = {1'b0, 8'h00, LT24_CMD_MEMWRITE};
            4'd11:   w = {1'b1, colour};
            default: w = {1'b1, 16'h0000};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lt24_bus_word.sv
// Two-phase 8080 write strobe: one word per WR_LO/WR_HI pair, done reported in WR_HI.
module lt24_bus_word
    import lt24_pixel_writer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        go,
    input  logic        rs_in,
    input  logic [15:0] data_in,
    output logic        done,
    output logic        wr_n,
    output logic        cs_n,
    output logic        rs,
    output logic [15:0] data
);

    bus_state_e  state_q, state_d;
    logic        wr_n_q, wr_n_d;
    logic        cs_n_q, cs_n_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wr_n_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            rs_q    <= 1'b1;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            wr_n_q  <= wr_n_d;
            cs_n_q  <= cs_n_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_n_d  = 1'b1;
        cs_n_d  = cs_n_q;
        rs_d    = rs_q;
        data_d  = data_q;
        if (go) begin
            // Bus word only changes here, so it is stable across the Wr_n rise.
            state_d = ST_WR_LO;
            wr_n_d  = 1'b0;
            cs_n_d  = 1'b0;
            rs_d    = rs_in;
            data_d  = data_in;
        end else begin
            case (state_q)
                ST_WR_LO: state_d = ST_WR_HI;
                ST_WR_HI: begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign done = (state_q == ST_WR_HI);
    assign wr_n = wr_n_q;
    assign cs_n = cs_n_q;
    assign rs   = rs_q;
    assign data = data_q;

endmodule

// File: rtl/lt24_pixel_writer.sv
// Pixel-to-LT24 transmitter: picks full-address or streamed colour-only sequences.
module lt24_pixel_writer
    import lt24_pixel_writer_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  pixelX,
    input  logic [8:0]  pixelY,
    input  logic [15:0] pixelColour,
    input  logic        pixelWrite,
    output logic        pixelReady,
    input  logic        invalidate,
    output logic        pixelError,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic [15:0] LT24Data
);

    localparam logic [15:0] X_END = 16'(WIDTH - 1);
    localparam logic [15:0] Y_END = 16'(HEIGHT - 1);

    logic        active_q, active_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] col_q, col_d;
    logic        valid_q, valid_d;
    logic [7:0]  last_x_q, last_x_d;
    logic [8:0]  last_y_q, last_y_d;
    logic        error_q, error_d;

    logic        done;
    logic        go;
    logic [16:0] go_word;
    logic        accept;
    logic        in_range;
    logic        same_row;
    logic        next_row;
    logic        stream;

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q <= 1'b0;
            idx_q    <= 4'd0;
            x_q      <= 8'd0;
            y_q      <= 9'd0;
            col_q    <= 16'h0000;
            valid_q  <= 1'b0;
            last_x_q <= 8'd0;
            last_y_q <= 9'd0;
            error_q  <= 1'b0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
            valid_q  <= valid_d;
            last_x_q <= last_x_d;
            last_y_q <= last_y_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        pixelReady = !active_q || (done && idx_q == LAST_IDX);
        accept     = pixelWrite && pixelReady;
        in_range   = ({8'h00, pixelX} <= X_END) && ({7'h00, pixelY} <= Y_END);
        same_row   = ({1'b0, pixelX} == {1'b0, last_x_q} + 9'd1)
                     && (pixelY == last_y_q);
        next_row   = ({8'h00, last_x_q} == X_END) && (pixelX == 8'd0)
                     && ({1'b0, pixelY} == {1'b0, last_y_q} + 10'd1)
                     && ({7'h00, last_y_q} < Y_END);
        stream     = valid_q && !invalidate && (same_row || next_row);

        active_d = active_q;
        idx_d    = idx_q;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        valid_d  = valid_q && !invalidate;
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        error_d  = 1'b0;
        go       = 1'b0;
        go_word  = {1'b1, 16'h0000};

        if (accept) begin
            if (in_range) begin
                // A streamed pixel jumps straight to the colour word.
                active_d = 1'b1;
                idx_d    = stream ? LAST_IDX : 4'd0;
                x_d      = pixelX;
                y_d      = pixelY;
                col_d    = pixelColour;
                valid_d  = 1'b1;
                last_x_d = pixelX;
                last_y_d = pixelY;
                go       = 1'b1;
                go_word  = seq_word(idx_d, pixelX, pixelY, pixelColour,
                                    X_END, Y_END);
            end else begin
                active_d = 1'b0;
                error_d  = 1'b1;
            end
        end else if (active_q && done) begin
            if (idx_q != LAST_IDX) begin
                idx_d   = idx_q + 4'd1;
                go      = 1'b1;
                go_word = seq_word(idx_d, x_q, y_q, col_q, X_END, Y_END);
            end else begin
                active_d = 1'b0;
            end
        end
    end

    lt24_bus_word u_bus (
        .clock   (clock),
        .reset   (reset),
        .go      (go),
        .rs_in   (go_word[16]),
        .data_in (go_word[15:0]),
        .done    (done),
        .wr_n    (LT24Wr_n),
        .cs_n    (LT24CS_n),
        .rs      (LT24RS),
        .data    (LT24Data)
    );

    assign pixelError = error_q;
    assign LT24Rd_n   = 1'b1;

endmodule
